// File: rtl/spi_pkg.sv
// Shared definitions for the multi-CS SPI master: state encoding, SPI mode
// encoding and width helpers.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic spi_mode_e to_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  function automatic logic mode_cpol(input spi_mode_e m);
    logic [1:0] b;
    b = m;
    return b[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    logic [1:0] b;
    b = m;
    return b[0];
  endfunction

  // Index width for a select or counter range; never narrower than one bit.
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider: counts CLK_DIV cycles per half-period while enabled, toggles SCK
// at each half-period end and flags that end as a leading or trailing edge.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic idle_lvl,
  output logic lead_stb,
  output logic trail_stb,
  output logic sck
);

  localparam int CNT_W = cs_width(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             half_end;

  assign half_end  = en && (cnt == DIV_LAST);
  assign lead_stb  = half_end && !phase;
  assign trail_stb = half_end && phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      sck   <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
      sck   <= idle_lvl;
    end else if (half_end) begin
      cnt   <= '0;
      phase <= ~phase;
      sck   <= ~sck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised SPI master with chip-select bursts. Optional feature macro
// SPI_LOOPBACK_EN adds an lb_en port that feeds MOSI back into the receiver.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_CS  = 1,
  parameter  int CLK_DIV = 4,
  localparam int CS_W    = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
`ifdef SPI_LOOPBACK_EN
  input  logic              lb_en,
`endif
  output logic [NUM_CS-1:0] CS_N
);

  localparam int CNT_W = cs_width(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  ph_cnt;
  spi_mode_e         mode_q, mode_d;
  logic              lsb_q, lsb_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic              hold_q;
  logic [DATA_W-1:0] tx_word, rx_shift, rx_next;
  logic [BC_W-1:0]   bit_cnt;
  logic [NUM_CS-1:0] cs_n_d;
  logic accept, from_idle, ph_last, timed, cpha_q;
  logic lead_stb, trail_stb, sample_stb, drive_stb, final_edge, miso_in;

  assign tx_ready  = (state == ST_IDLE) || (state == ST_PAUSE);
  assign busy      = (state != ST_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign from_idle = (state == ST_IDLE);
  assign ph_last   = (ph_cnt == DIV_LAST);
  assign timed     = (state == ST_SETUP) || (state == ST_HOLD) || (state == ST_GAP);

  // Mode, order and select only change when a burst starts from IDLE.
  assign mode_d = (accept && from_idle) ? to_mode(cpol, cpha) : mode_q;
  assign lsb_d  = (accept && from_idle) ? lsb_first : lsb_q;
  assign cs_d   = (accept && from_idle) ? cs_sel : cs_q;
  assign cpha_q = mode_cpha(mode_q);

`ifdef SPI_LOOPBACK_EN
  assign miso_in = lb_en ? MOSI : MISO;
`else
  assign miso_in = MISO;
`endif

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ST_SHIFT),
    .idle_lvl  (mode_cpol(mode_d)),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .sck       (SCK)
  );

  assign sample_stb = cpha_q ? trail_stb : lead_stb;
  assign drive_stb  = cpha_q ? lead_stb : trail_stb;
  // The last SCK edge is always a trailing one; CPHA=1 samples on it too.
  assign final_edge = trail_stb && (bit_cnt == (cpha_q ? BC_LAST : BC_FULL));

  function automatic logic pick_bit(input logic [DATA_W-1:0] w,
                                    input logic [BC_W-1:0] idx, input logic lsb);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == int'(idx)) b = lsb ? w[i] : w[DATA_W-1-i];
    return b;
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    rx_next = {rx_shift[DATA_W-2:0], miso_in};
    if (lsb_q) rx_next = {miso_in, rx_shift[DATA_W-1:1]};
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (accept)     state_d = ST_SETUP;
      ST_SETUP: if (ph_last)    state_d = ST_SHIFT;
      ST_SHIFT: if (final_edge) state_d = ST_HOLD;
      ST_HOLD:  if (ph_last)    state_d = hold_q ? ST_PAUSE : ST_GAP;
      ST_PAUSE: if (accept)     state_d = ST_SHIFT;
      ST_GAP:   if (ph_last)    state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // An out-of-range select leaves every CS_N high.
  always_comb begin
    cs_n_d = '1;
    if (state_d == ST_SETUP || state_d == ST_SHIFT ||
        state_d == ST_HOLD  || state_d == ST_PAUSE)
      for (int i = 0; i < NUM_CS; i++)
        if (int'(cs_d) == i) cs_n_d[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ph_cnt   <= '0;
      mode_q   <= MODE0;
      lsb_q    <= 1'b0;
      cs_q     <= '0;
      hold_q   <= 1'b0;
      tx_word  <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      MOSI     <= 1'b0;
      CS_N     <= '1;
    end else begin
      state    <= state_d;
      mode_q   <= mode_d;
      lsb_q    <= lsb_d;
      cs_q     <= cs_d;
      CS_N     <= cs_n_d;
      rx_valid <= final_edge;
      ph_cnt   <= (state_d != state || !timed) ? '0 : ph_cnt + CNT_W'(1);
      if (accept) begin
        tx_word  <= tx_data;
        hold_q   <= hold_cs;
        bit_cnt  <= '0;
        rx_shift <= '0;
        // CPHA=0 must present the first bit before the first (sampling) edge.
        if (!mode_cpha(mode_d)) MOSI <= pick_bit(tx_data, '0, lsb_d);
      end else if (state == ST_SHIFT) begin
        if (sample_stb) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + BC_W'(1);
        end
        if (drive_stb && bit_cnt < BC_FULL) MOSI <= pick_bit(tx_word, bit_cnt, lsb_q);
        if (final_edge) rx_data <= cpha_q ? rx_next : rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc: a timeline model of the pins plus an
// SPI slave model, compared every cycle, and directed word scenarios.
module tb_spi_master_mc;

  localparam int DW = 8;
  localparam int NCS = 4;
  localparam int CD = 4;

  logic clk = 1'b0;
  logic rst, tx_valid, tx_ready, hold_cs, cpol, cpha, lsb_first;
  logic rx_valid, busy, SCK, MOSI, MISO, lb_en;
  logic [DW-1:0]  tx_data, rx_data;
  logic [1:0]     cs_sel;
  logic [NCS-1:0] CS_N;

  always #5 clk = ~clk;

  spi_master_mc #(.DATA_W(DW), .NUM_CS(NCS), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .cs_sel(cs_sel), .hold_cs(hold_cs), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
`ifdef SPI_LOOPBACK_EN
    .lb_en(lb_en),
`endif
    .CS_N(CS_N)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the current word: start cycle and latched settings.
  bit m_active = 0, m_from_idle, m_hold, m_cpol = 0, m_cpha, m_lsb, m_lb, m_idle = 1;
  bit m_start_pending = 0, exp_ready = 1;
  int m_w0, m_cs, t_rv, rv_count = 0;
  logic [DW-1:0]  m_tx, m_slv, m_last_rx = '0, slave_word = '0, s_mosi = '0;
  logic [NCS-1:0] cs_low_seen = '0;

  function automatic int bitpos(input int i, input bit lsb);
    return lsb ? i : DW - 1 - i;
  endfunction

  function automatic logic [NCS-1:0] sel_mask(input int cs);
    logic [NCS-1:0] m;
    m = '1;
    if (cs < NCS) m[cs] = 1'b0;
    return m;
  endfunction

  initial begin : compare
    int off, pre, sh_end, len, s_smp, s_drv;
    logic e_sck, e_busy, e_ready, e_rv, sck_prev;
    logic [NCS-1:0] e_csn;
    MISO = 1'b0;
    sck_prev = 1'b0;
    s_smp = 0;
    s_drv = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 0; m_cpol = 0; m_last_rx = '0; m_hold = 0; MISO = 1'b0;
      end else if (tx_valid && exp_ready) begin
        m_from_idle = m_idle;
        if (m_from_idle) begin
          m_cpol = cpol; m_cpha = cpha; m_lsb = lsb_first; m_cs = int'(cs_sel);
        end
        m_hold = hold_cs; m_tx = tx_data; m_slv = slave_word; m_w0 = cyc; m_active = 1;
`ifdef SPI_LOOPBACK_EN
        m_lb = lb_en;
`else
        m_lb = 0;
`endif
        s_mosi = '0; s_smp = 0; s_drv = 0; m_start_pending = 1;
      end
      @(negedge clk);
      e_sck = m_cpol; e_csn = '1; e_busy = 0; e_ready = 1; e_rv = 0;
      off = cyc - m_w0;
      pre = m_from_idle ? CD : 0;
      sh_end = pre + 2 * DW * CD;
      len = sh_end + CD;
      if (m_active) begin
        if (off < len) begin
          e_busy = 1; e_ready = 0; e_csn = sel_mask(m_cs);
          if (off >= pre && off < sh_end) e_sck = m_cpol ^ (((off - pre) / CD) % 2 == 1);
          e_rv = (off == sh_end);
        end else if (m_hold) begin
          e_busy = 1; e_csn = sel_mask(m_cs);
        end else if (off < len + CD) begin
          e_busy = 1; e_ready = 0;
        end
      end
      // Slave: react to observed SCK edges within the shift window.
      if (m_active && m_start_pending) begin
        m_start_pending = 0;
        if (!m_cpha) begin MISO = m_slv[bitpos(0, m_lsb)]; s_drv = 1; end
      end
      if (m_active && SCK !== sck_prev && off > pre && off <= sh_end) begin
        if ((SCK != m_cpol) != m_cpha) begin
          if (s_smp < DW) begin s_mosi[bitpos(s_smp, m_lsb)] = MOSI; s_smp++; end
        end else if (s_drv < DW) begin
          MISO = m_slv[bitpos(s_drv, m_lsb)]; s_drv++;
        end
      end
      sck_prev = SCK;
      if (m_active && e_rv) begin
        m_last_rx = m_lb ? m_tx : m_slv;
        t_rv = cyc;
        check("mosi_word", 32'(s_mosi), 32'(m_tx));
      end
      check("sck", 32'(SCK), 32'(e_sck));
      check("cs_n", 32'(CS_N), 32'(e_csn));
      check("busy", 32'(busy), 32'(e_busy));
      check("tx_ready", 32'(tx_ready), 32'(e_ready));
      check("rx_valid", 32'(rx_valid), 32'(e_rv));
      check("rx_data", 32'(rx_data), 32'(m_last_rx));
      if (rx_valid === 1'b1) rv_count++;
      cs_low_seen |= ~CS_N;
      exp_ready = e_ready;
      m_idle = !e_busy;
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] sw, input int cs,
                      input bit hold, input bit pol, input bit pha, input bit lsb);
    int n;
    logic [31:0] csv;
    csv = cs;
    slave_word = sw; tx_data = d; cs_sel = csv[1:0]; hold_cs = hold;
    cpol = pol; cpha = pha; lsb_first = lsb; tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("accept_timeout", 32'(n), 32'(0));
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("idle_timeout", 32'(n), 32'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] t2_tx [3];
    int rv0;
    t2_tx = '{8'h3C, 8'h96, 8'hE7};
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; cs_sel = '0; hold_cs = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; lb_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mosi", 32'(MOSI), 32'(0));
    check("rst_ready", 32'(tx_ready), 32'(1));
    check("rst_csn", 32'(CS_N), 32'hF);
    check("rst_sck", 32'(SCK), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));

    // 1: mode 0, MISO all ones
    send(8'hC9, 8'hFF, 0, 0, 0, 0, 0);
    wait_idle();
    check("t1_rx", 32'(rx_data), 32'hFF);
    check("t1_mosi", 32'(s_mosi), 32'hC9);
    check("t1_latency", 32'(t_rv - (m_w0 - 1)), 32'd69);

    // 2: modes 1..3, slave returns A5
    for (int i = 1; i < 4; i++) begin
      send(t2_tx[i-1], 8'hA5, 1, 0, i[1], i[0], 0);
      wait_idle();
      check("t2_rx", 32'(rx_data), 32'hA5);
      check("t2_sck_idle", 32'(SCK), 32'(i[1]));
    end

    // 3: LSB first
    send(8'h01, 8'h80, 0, 0, 0, 0, 1);
    wait_idle();
    check("t3_rx", 32'(rx_data), 32'h80);
    check("t3_mosi", 32'(s_mosi), 32'h01);

    // 4: three-word burst on CS 2; later select/mode inputs must be ignored
    rv0 = rv_count;
    cs_low_seen = '0;
    send(8'h11, 8'hEE, 2, 1, 0, 0, 0);
    check("t4_csn_w1", 32'(CS_N), 32'b1011);
    send(8'h22, 8'hDD, 0, 1, 1, 1, 1);
    check("t4_csn_w2", 32'(CS_N), 32'b1011);
    send(8'h33, 8'hCC, 1, 0, 1, 0, 1);
    check("t4_csn_w3", 32'(CS_N), 32'b1011);
    wait_idle();
    check("t4_rx", 32'(rx_data), 32'hCC);
    check("t4_pulses", 32'(rv_count - rv0), 32'd3);
    check("t4_cs_only2", 32'(cs_low_seen), 32'b0100);

    // 5: reset in the middle of the shift phase
    send(8'h96, 8'h69, 0, 0, 0, 0, 0);
    repeat (10 * CD) @(negedge clk);
    check("t5_busy_pre", 32'(busy), 32'(1));
    rv0 = rv_count;
    rst = 1'b1;
    @(negedge clk);
    check("t5_csn", 32'(CS_N), 32'hF);
    check("t5_sck", 32'(SCK), 32'(0));
    check("t5_rv", 32'(rx_valid), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (20 * CD) @(negedge clk);
    check("t5_no_pulse", 32'(rv_count - rv0), 32'd0);
    send(8'h3C, 8'hC3, 1, 0, 0, 0, 0);
    wait_idle();
    check("t5_rx_after", 32'(rx_data), 32'hC3);

    // 6: loopback request with MISO low
    lb_en = 1'b1;
    send(8'h5A, 8'h00, 0, 0, 0, 0, 0);
    wait_idle();
`ifdef SPI_LOOPBACK_EN
    check("t6_rx", 32'(rx_data), 32'h5A);
`else
    check("t6_rx", 32'(rx_data), 32'h00);
`endif
    lb_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
